rsr_tx_sequencer: RTL

//   Frames a parallel word and shifts it out serially, LSB first, on SO. Frame = start bit (0), BITS data bits,

---
 rtl/rsr_tx_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rsr_tx_sequencer.sv
// -----------------------------------------------------------------------------
// rsr_tx_sequencer
//   Takes a parallel word over a valid/ready handshake and shifts it out
//   serially, LSB first, framed as: start bit (0), BITS data bits, optional
//   even-parity bit, stop bit (1). Each serial bit lasts DIV clock cycles.
//   All outputs are registered; nothing combinational runs from inputs to
//   outputs.
//
// Ports
//   CLK    in   clock, all state updates on posedge
//   RST    in   asynchronous active-high reset
//   data   in   [BITS-1:0] word to transmit, sampled on accept
//   Valid  in   producer has a word on data
//   Ready  out  sequencer can accept a word (IDLE only)
//   SO     out  serial output, idle-high
//   Busy   out  frame in progress
//   Done   out  one-cycle pulse after the stop bit completes
// -----------------------------------------------------------------------------
module rsr_tx_sequencer #(
    parameter int BITS      = 4,
    parameter int DIV       = 4,
    parameter int PARITY_EN = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [BITS-1:0] data,
    input  logic            Valid,
    output logic            Ready,
    output logic            SO,
    output logic            Busy,
    output logic            Done
);

    // Divider must hold DIV-1; keep at least one bit so DIV=1 stays legal.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(BITS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [BITS-1:0]   shreg_q, shreg_d;
    logic              par_q,   par_d;
    logic              so_q,    so_d;
    logic              ready_q, ready_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              bit_end;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            so_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            so_q    <= so_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_d  = 1'b0;
        bit_end = (div_q == DIV_W'(DIV - 1));

        case (state_q)
            IDLE: begin
                if (Valid && ready_q) begin
                    shreg_d = data;
                    par_d   = ^data;
                    div_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BITS - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bit-period divider free-runs in every framing state and restarts
        // at each bit boundary; with DIV=1 bit_end is always true.
        if (state_q != IDLE) begin
            div_d = bit_end ? '0 : div_q + DIV_W'(1);
        end

        // Outputs are computed from the next state so the registered value
        // lines up with the state it belongs to.
        case (state_d)
            START:   so_d = 1'b0;
            DATA:    so_d = shreg_d[0];
            PARITY:  so_d = par_d;
            default: so_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign Ready = ready_q;
    assign SO    = so_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule
